// File: rtl/hazard_pkg.sv
// Shared types and encodings for the decode/execute hazard controller.
package hazard_pkg;

  // Operand source selects for the instruction in EX
  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  // Scoreboard stage indices (age order: EX is the youngest producer)
  localparam int STG_EX   = 0;
  localparam int STG_MEM  = 1;
  localparam int STG_WB   = 2;
  localparam int N_STAGES = 3;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } sb_entry_t;

  // Nearest producer wins: whatever is in EX now will be in MEM when the
  // consumer reaches EX, and whatever is in MEM now will be in WB.
  function automatic logic [1:0] fwd_select(input logic [N_STAGES-1:0] match);
    if (match[STG_EX])       return FWD_MEM;
    else if (match[STG_MEM]) return FWD_WB;
    else                     return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-entry destination-register tracker (EX, MEM, WB) with match ports.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int N_QUERY = 2
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_push_valid,
  input  logic [4:0]                    i_push_rd,
  input  logic                          i_push_is_load,
  input  logic [N_QUERY-1:0][4:0]       i_src,
  output logic [N_QUERY-1:0][N_STAGES-1:0] o_match,
  output logic                          o_ex_is_load
);

  sb_entry_t r_stage [N_STAGES];
  sb_entry_t w_push;

  // rd=x0 never produces a tracked entry
  assign w_push.valid   = i_push_valid & (i_push_rd != 5'd0);
  assign w_push.rd      = i_push_rd;
  assign w_push.is_load = i_push_is_load;

  // Shift register: the pipeline below decode always advances
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < N_STAGES; i++) r_stage[i] <= '0;
    end else begin
      r_stage[STG_EX]  <= w_push;
      r_stage[STG_MEM] <= r_stage[STG_EX];
      r_stage[STG_WB]  <= r_stage[STG_MEM];
    end
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < N_QUERY; gi++) begin : g_query
      for (gj = 0; gj < N_STAGES; gj++) begin : g_stage
        assign o_match[gi][gj] = (i_src[gi] != 5'd0) && r_stage[gj].valid &&
                                 (r_stage[gj].rd == i_src[gi]);
      end
    end
  endgenerate

  assign o_ex_is_load = r_stage[STG_EX].is_load;

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage stall and EX forwarding-select generator for the 5-stage core.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter bit FORWARDING = 1'b1,
  parameter bit WB_BYPASS  = 1'b1
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_dec_valid,
  input  logic [4:0]  i_dec_rs1,
  input  logic [4:0]  i_dec_rs2,
  input  logic [4:0]  i_dec_rd,
  input  logic        i_dec_reg_write_enable,
  input  logic        i_dec_mem_or_alu,
  input  logic        i_flush,
  output logic        o_stall,
  output logic        o_ex_valid,
  output logic [1:0]  o_fwd_a,
  output logic [1:0]  o_fwd_b,
  output logic [31:0] o_stall_count
);

  logic [1:0][4:0]          w_src;
  logic [1:0][N_STAGES-1:0] w_match;
  logic [1:0]               w_hazard;
  logic                     w_ex_is_load;
  logic                     w_issue;
  logic                     r_ex_valid;
  logic [1:0]               r_fwd_a;
  logic [1:0]               r_fwd_b;
  logic [31:0]              r_stall_count;

  assign w_src[0] = i_dec_rs1;
  assign w_src[1] = i_dec_rs2;

  hazard_scoreboard #(.N_QUERY(2)) u_scoreboard (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_push_valid   (w_issue & i_dec_reg_write_enable),
    .i_push_rd      (i_dec_rd),
    .i_push_is_load (~i_dec_mem_or_alu),
    .i_src          (w_src),
    .o_match        (w_match),
    .o_ex_is_load   (w_ex_is_load)
  );

  // With forwarding only a load in EX blocks; without it the producer must
  // reach WB (or leave WB when the register file has no write-through).
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_hazard
      if (FORWARDING) begin : g_fwd
        assign w_hazard[gi] = (w_match[gi][STG_EX] & w_ex_is_load) |
                              (~WB_BYPASS & w_match[gi][STG_WB]);
      end else begin : g_nofwd
        assign w_hazard[gi] = w_match[gi][STG_EX] | w_match[gi][STG_MEM] |
                              (~WB_BYPASS & w_match[gi][STG_WB]);
      end
    end
  endgenerate

  // Flush always wins over a hazard
  assign o_stall = i_dec_valid & ~i_flush & (|w_hazard);
  assign w_issue = i_dec_valid & ~o_stall & ~i_flush;

  // EX valid and forwarding selects captured as the instruction issues
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_ex_valid <= 1'b0;
      r_fwd_a    <= FWD_RF;
      r_fwd_b    <= FWD_RF;
    end else begin
      r_ex_valid <= w_issue;
      r_fwd_a    <= (w_issue && FORWARDING) ? fwd_select(w_match[0]) : FWD_RF;
      r_fwd_b    <= (w_issue && FORWARDING) ? fwd_select(w_match[1]) : FWD_RF;
    end
  end

  // Saturating count of stalled cycles
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_stall_count <= '0;
    end else if (o_stall && (r_stall_count != 32'hFFFF_FFFF)) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign o_ex_valid    = r_ex_valid;
  assign o_fwd_a       = r_fwd_a;
  assign o_fwd_b       = r_fwd_b;
  assign o_stall_count = r_stall_count;

endmodule
